mc_ctrl: RTL and testbench

Multi-cycle control unit for the RV32I core. Sequences one instruction at a time through fetch, decode, execute, memory and writeback over a single shared memory port. Drives the immediate generator's `SEXT_op`, the ALU operand and operation selects, register-file write and PC update. Sits between the instruction register and the datapath, with the datapath holding IR, PC, ALU and SEXT.

---
 rtl/mc_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mc_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: BOOT/FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// Optional perf counters under `MC_CTRL_PERF_EN`; SEXT_op_* codes mirror defines.vh.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        npc_sel,
  output logic [2:0]  SEXT_op,
  output logic [3:0]  alu_op,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wd_sel,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam logic [2:0] SEXT_op_NONE = 3'd0;
  localparam logic [2:0] SEXT_op_I    = 3'd1;
  localparam logic [2:0] SEXT_op_S    = 3'd2;
  localparam logic [2:0] SEXT_op_B    = 3'd3;
  localparam logic [2:0] SEXT_op_U    = 3'd4;
  localparam logic [2:0] SEXT_op_J    = 3'd5;

  typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [3:0] {
    C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_FENCE, C_ILL
  } cls_t;

  function automatic cls_t decode_cls(input logic [6:0] opc);
    case (opc)
      7'b0110011: return C_OP;
      7'b0010011: return C_OPIMM;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      7'b0001111: return C_FENCE;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] sext_of(input cls_t c);
    case (c)
      C_OPIMM, C_LOAD, C_JALR: return SEXT_op_I;
      C_STORE:                 return SEXT_op_S;
      C_BRANCH:                return SEXT_op_B;
      C_LUI, C_AUIPC:          return SEXT_op_U;
      C_JAL:                   return SEXT_op_J;
      default:                 return SEXT_op_NONE;
    endcase
  endfunction

  state_t      state;
  cls_t        cls;
  cls_t        dec_cls;
  logic [2:0]  funct3;
  logic        unused_inst;

  assign dec_cls     = decode_cls(inst[6:0]);
  assign funct3      = inst[14:12];
  assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      cls   <= C_ILL;
    end else begin
      case (state)
        BOOT:   state <= FETCH;
        FETCH:  if (mem_ready) state <= DECODE;
        DECODE: begin
          cls   <= dec_cls;
          state <= (dec_cls == C_ILL || dec_cls == C_FENCE) ? FETCH : EXEC;
        end
        EXEC: begin
          case (cls)
            C_BRANCH:        state <= FETCH;
            C_LOAD, C_STORE: state <= MEM;
            default:         state <= WB;
          endcase
        end
        MEM:     if (mem_ready) state <= (cls == C_STORE) ? FETCH : WB;
        WB:      state <= FETCH;
        default: state <= BOOT;
      endcase
    end
  end

  // Outputs decode from the state register only (plus inst/handshake inputs), so an
  // asynchronous reset forces BOOT and silences every output without waiting for a clock.
  always_comb begin
    mem_req   = 1'b0;
    mem_sel   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    npc_sel   = 1'b0;
    SEXT_op   = SEXT_op_NONE;
    alu_op    = 4'b0000;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_we     = 1'b0;
    wd_sel    = 2'b00;
    illegal   = 1'b0;
    if (state == EXEC || state == MEM || state == WB) begin
      SEXT_op = sext_of(cls);
      case (cls)
        C_OP:    alu_op = {inst[30], funct3};
        C_OPIMM: begin
          alu_b_sel = 1'b1;
          alu_op    = {inst[30] & (funct3 == 3'b101), funct3};
        end
        C_LOAD, C_STORE, C_JALR:   alu_b_sel = 1'b1;
        C_AUIPC, C_JAL, C_BRANCH: begin
          alu_a_sel = 1'b1;
          alu_b_sel = 1'b1;
        end
        default: ;
      endcase
    end
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      DECODE: begin
        SEXT_op = sext_of(dec_cls);
        if (dec_cls == C_ILL || dec_cls == C_FENCE) begin
          pc_we   = 1'b1;
          illegal = (dec_cls == C_ILL);
        end
      end
      EXEC: begin
        if (cls == C_BRANCH) begin
          pc_we   = 1'b1;
          npc_sel = br_taken;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (cls == C_STORE);
        pc_we   = (cls == C_STORE) & mem_ready;
      end
      WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        npc_sel = (cls == C_JAL || cls == C_JALR);
        case (cls)
          C_LOAD:         wd_sel = 2'b01;
          C_JAL, C_JALR:  wd_sel = 2'b10;
          C_LUI:          wd_sel = 2'b11;
          default:        wd_sel = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  // An instruction retires exactly on its pc_we pulse, including illegal and FENCE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Cycle-level scoreboard bench for mc_ctrl: per-cycle expected control vectors are queued
// as each instruction is scheduled and compared (under a field mask) as the cycles run.
module tb_mc_ctrl;

  localparam logic [2:0] SX_NONE = 3'd0, SX_I = 3'd1, SX_S = 3'd2,
                         SX_B = 3'd3, SX_U = 3'd4, SX_J = 3'd5;

  typedef struct packed {
    logic       mem_req, mem_sel, mem_we, ir_we, pc_we, npc_sel;
    logic [2:0] sext;
    logic [3:0] alu_op;
    logic       a_sel, b_sel, rf_we;
    logic [1:0] wd;
    logic       ill;
  } ctl_t;

  typedef struct {
    string       tag;
    ctl_t        e;
    ctl_t        m;
    logic        rdy;
    logic        tk;
    logic [31:0] ins;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        mem_ready, br_taken;
  logic        mem_req, mem_sel, mem_we, ir_we, pc_we, npc_sel;
  logic [2:0]  SEXT_op;
  logic [3:0]  alu_op;
  logic        alu_a_sel, alu_b_sel, rf_we, illegal;
  logic [1:0]  wd_sel;
  logic [31:0] cycle_cnt, instret_cnt;

  int    total = 0;
  int    bad   = 0;
  int    ncyc  = 0;
  int    exp_ret = 0;
  item_t sb[$];

  mc_ctrl dut (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .npc_sel(npc_sel), .SEXT_op(SEXT_op), .alu_op(alu_op), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .rf_we(rf_we), .wd_sel(wd_sel), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  function automatic ctl_t observed();
    return {mem_req, mem_sel, mem_we, ir_we, pc_we, npc_sel, SEXT_op, alu_op,
            alu_a_sel, alu_b_sel, rf_we, wd_sel, illegal};
  endfunction

  function automatic ctl_t pulse_mask();
    ctl_t m = '0;
    m.mem_req = 1'b1; m.mem_sel = 1'b1; m.mem_we = 1'b1; m.ir_we = 1'b1;
    m.pc_we = 1'b1; m.rf_we = 1'b1; m.ill = 1'b1;
    return m;
  endfunction

  task automatic chk_ctl(input string tag, input ctl_t o, input ctl_t x, input ctl_t m);
    total++;
    assert ((o & m) === (x & m)) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h mask=%h", tag, o, x, m);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, x);
    end
  endtask

  task automatic push(input string tag, input ctl_t e, input ctl_t m, input logic rdy,
                      input logic tk, input logic [31:0] ins);
    item_t it;
    it.tag = tag; it.e = e; it.m = m; it.rdy = rdy; it.tk = tk; it.ins = ins;
    sb.push_back(it);
  endtask

  task automatic push_boot();
    push("boot", '0, '1, 1'b0, 1'b0, 32'd0);
  endtask

  // Reference model: expected per-cycle control for one instruction, fw/mw wait cycles.
  task automatic push_instr(input logic [31:0] ins, input int fw, input int mw,
                            input logic tk, input string tag);
    ctl_t e, m;
    logic [2:0] f3, sx;
    logic [3:0] aop;
    logic [1:0] wd;
    logic asel, bsel, has_alu, is_mem, is_st, is_br, is_j, nop, ill;
    f3 = ins[14:12]; sx = SX_NONE; aop = 4'b0000; wd = 2'b00;
    asel = 0; bsel = 0; has_alu = 0; is_mem = 0; is_st = 0; is_br = 0; is_j = 0; nop = 0; ill = 0;
    case (ins[6:0])
      7'b0110011: begin has_alu = 1; aop = {ins[30], f3}; end
      7'b0010011: begin sx = SX_I; has_alu = 1; bsel = 1; aop = {ins[30] && (f3 == 3'b101), f3}; end
      7'b0000011: begin sx = SX_I; has_alu = 1; bsel = 1; is_mem = 1; wd = 2'b01; end
      7'b0100011: begin sx = SX_S; has_alu = 1; bsel = 1; is_mem = 1; is_st = 1; end
      7'b1100011: begin sx = SX_B; has_alu = 1; asel = 1; bsel = 1; is_br = 1; end
      7'b1101111: begin sx = SX_J; has_alu = 1; asel = 1; bsel = 1; is_j = 1; wd = 2'b10; end
      7'b1100111: begin sx = SX_I; has_alu = 1; bsel = 1; is_j = 1; wd = 2'b10; end
      7'b0110111: begin sx = SX_U; wd = 2'b11; end
      7'b0010111: begin sx = SX_U; has_alu = 1; asel = 1; bsel = 1; end
      7'b0001111: nop = 1;
      default:    ill = 1;
    endcase
    exp_ret++;
    for (int w = 0; w <= fw; w++) begin
      e = '0; m = pulse_mask();
      e.mem_req = 1'b1; e.ir_we = (w == fw);
      push({tag, "/fetch"}, e, m, w == fw, tk, ins);
    end
    e = '0; m = pulse_mask();
    if (ill || nop) begin
      e.pc_we = 1'b1; e.ill = ill; m.npc_sel = 1'b1;
      push({tag, "/decode"}, e, m, 1'b0, tk, ins);
      return;
    end
    e.sext = sx; m.sext = '1;
    push({tag, "/decode"}, e, m, 1'b0, tk, ins);
    if (has_alu) begin
      m.alu_op = '1; m.a_sel = 1'b1; m.b_sel = 1'b1;
      e.alu_op = aop; e.a_sel = asel; e.b_sel = bsel;
    end
    if (is_br) begin
      e.pc_we = 1'b1; e.npc_sel = tk; m.npc_sel = 1'b1;
      push({tag, "/exec"}, e, m, 1'b0, tk, ins);
      return;
    end
    push({tag, "/exec"}, e, m, 1'b0, tk, ins);
    if (is_mem) begin
      for (int w = 0; w <= mw; w++) begin
        e.mem_req = 1'b1; e.mem_sel = 1'b1; e.mem_we = is_st;
        e.pc_we = is_st && (w == mw); m.npc_sel = e.pc_we; e.npc_sel = 1'b0;
        push({tag, "/mem"}, e, m, w == mw, tk, ins);
      end
      if (is_st) return;
    end
    e.mem_req = 0; e.mem_sel = 0; e.mem_we = 0;
    e.rf_we = 1'b1; e.pc_we = 1'b1; e.wd = wd; e.npc_sel = is_j;
    m.wd = '1; m.npc_sel = 1'b1;
    if (!is_j) begin m.alu_op = '0; m.a_sel = 1'b0; m.b_sel = 1'b0; end
    push({tag, "/wb"}, e, m, 1'b0, tk, ins);
  endtask

  // Runs up to n queued cycles (n < 0: all); inputs at posedge+1, outputs sampled at negedge.
  task automatic drain(input int n);
    item_t it;
    int k = 0;
    while (sb.size() > 0 && (n < 0 || k < n)) begin
      it = sb.pop_front();
      inst = it.ins; mem_ready = it.rdy; br_taken = it.tk;
      @(negedge clk);
      chk_ctl(it.tag, observed(), it.e, it.m);
      ncyc++; k++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef MC_CTRL_PERF_EN
    chk32({tag, "/instret"}, instret_cnt, 32'(exp_ret));
    chk32({tag, "/cycle"}, cycle_cnt, 32'(ncyc));
`else
    chk32({tag, "/instret"}, instret_cnt, 32'd0);
    chk32({tag, "/cycle"}, cycle_cnt, 32'd0);
`endif
  endtask

  task automatic run(input logic [31:0] ins, input int fw, input int mw, input logic tk,
                     input string tag);
    push_instr(ins, fw, mw, tk, tag);
    drain(-1);
    chk_cnt(tag);
  endtask

  task automatic release_rst();
    rst = 1'b0; ncyc = 0; exp_ret = 0;
    push_boot();
  endtask

  initial begin
    ctl_t pre;
    rst = 1'b1; inst = 32'd0; mem_ready = 1'b0; br_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_ctl("in_reset", observed(), '0, '1);
    chk32("in_reset/instret", instret_cnt, 32'd0);
    chk32("in_reset/cycle", cycle_cnt, 32'd0);

    release_rst();
    run(32'h002081B3, 0, 0, 1'b0, "add");
    run(32'h0040A183, 0, 3, 1'b0, "lw");
    run(32'h00208463, 0, 0, 1'b1, "beq_t");
    run(32'h00208463, 0, 0, 1'b0, "beq_nt");
    run(32'h008000EF, 0, 0, 1'b0, "jal");
    run(32'h0000007F, 0, 0, 1'b0, "illegal");
    run(32'h00000073, 1, 0, 1'b0, "system");
    run(32'h0000000F, 0, 0, 1'b0, "fence");
    run(32'h4010D093, 0, 0, 1'b0, "srai");
    run(32'hC0000093, 0, 0, 1'b0, "addi_b30");
    run(32'h40208133, 2, 0, 1'b0, "sub");
    run(32'h123450B7, 0, 0, 1'b0, "lui");
    run(32'h00000097, 0, 0, 1'b0, "auipc");
    run(32'h000080E7, 0, 0, 1'b1, "jalr");
    run(32'h0020A223, 2, 1, 1'b0, "sw");
    run(32'h0020A223, 0, 0, 1'b0, "sw_zw");

    // Abort a store mid-access with the memory stalled.
    push_instr(32'h0020A223, 0, 8, 1'b0, "sw_abort");
    drain(5);
    inst = 32'h0020A223; mem_ready = 1'b0;
    #1;
    pre = '0; pre.mem_req = 1'b1; pre.mem_sel = 1'b1; pre.mem_we = 1'b1;
    chk_ctl("sw_abort/pre", observed(), pre, pulse_mask());
    #1 rst = 1'b1;
    #1;
    chk_ctl("sw_abort/rst", observed(), '0, '1);
    chk32("sw_abort/instret", instret_cnt, 32'd0);
    chk32("sw_abort/cycle", cycle_cnt, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    release_rst();
    run(32'h002081B3, 0, 0, 1'b0, "add_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
